// File: rtl/decode_issue_queue.sv
// Show-ahead FIFO between the decode mux and the issue stage.
// Stall leaves one spare slot for the mux's in-flight registered record.
module decode_issue_queue #(
    parameter int depth                   = 8,
    parameter int addressWidth            = 64,
    parameter int opcodeSize              = 12,
    parameter int funcUnitCodeSize        = 3,
    parameter int instructionCounterWidth = 64,
    parameter int instMinIdWidth          = 7,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int regAccessPatternSize    = 2,
    parameter int bodyWidth               = 84
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               enable_i,
    input  logic [opcodeSize-1:0]              opcode_i,
    input  logic [addressWidth-1:0]            address_i,
    input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
    input  logic [instructionCounterWidth-1:0] majID_i,
    input  logic [instMinIdWidth-1:0]          minID_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 pid_i,
    input  logic [TidSize-1:0]                 tid_i,
    input  logic [regAccessPatternSize-1:0]    op1rw_i,
    input  logic [regAccessPatternSize-1:0]    op2rw_i,
    input  logic [regAccessPatternSize-1:0]    op3rw_i,
    input  logic [regAccessPatternSize-1:0]    op4rw_i,
    input  logic                               op1IsReg_i,
    input  logic                               op2IsReg_i,
    input  logic                               op3IsReg_i,
    input  logic                               op4IsReg_i,
    input  logic [bodyWidth-1:0]               body_i,
    input  logic                               ready_i,
    output logic [opcodeSize-1:0]              opcode_o,
    output logic [addressWidth-1:0]            address_o,
    output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
    output logic [instructionCounterWidth-1:0] majID_o,
    output logic [instMinIdWidth-1:0]          minID_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 pid_o,
    output logic [TidSize-1:0]                 tid_o,
    output logic [regAccessPatternSize-1:0]    op1rw_o,
    output logic [regAccessPatternSize-1:0]    op2rw_o,
    output logic [regAccessPatternSize-1:0]    op3rw_o,
    output logic [regAccessPatternSize-1:0]    op4rw_o,
    output logic                               op1IsReg_o,
    output logic                               op2IsReg_o,
    output logic                               op3IsReg_o,
    output logic                               op4IsReg_o,
    output logic [bodyWidth-1:0]               body_o,
    output logic                               valid_o,
    output logic                               stall_o,
    output logic                               overflow_o,
    output logic [$clog2(depth):0]             count_o
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] full_cnt = (aw+1)'(depth);

    typedef struct packed {
        logic [opcodeSize-1:0]              opcode;
        logic [addressWidth-1:0]            address;
        logic [funcUnitCodeSize-1:0]        func_unit;
        logic [instructionCounterWidth-1:0] maj_id;
        logic [instMinIdWidth-1:0]          min_id;
        logic                               is_64bit;
        logic [PidSize-1:0]                 pid;
        logic [TidSize-1:0]                 tid;
        logic [regAccessPatternSize-1:0]    op1rw;
        logic [regAccessPatternSize-1:0]    op2rw;
        logic [regAccessPatternSize-1:0]    op3rw;
        logic [regAccessPatternSize-1:0]    op4rw;
        logic                               op1_is_reg;
        logic                               op2_is_reg;
        logic                               op3_is_reg;
        logic                               op4_is_reg;
        logic [bodyWidth-1:0]               body;
    } entry_t;

    entry_t        mem [depth];
    entry_t        wr_entry;
    entry_t        head;
    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr;
    logic [aw:0]   count;
    logic          push;
    logic          pop;

    assign wr_entry = '{
        opcode:     opcode_i,
        address:    address_i,
        func_unit:  funcUnitType_i,
        maj_id:     majID_i,
        min_id:     minID_i,
        is_64bit:   is64Bit_i,
        pid:        pid_i,
        tid:        tid_i,
        op1rw:      op1rw_i,
        op2rw:      op2rw_i,
        op3rw:      op3rw_i,
        op4rw:      op4rw_i,
        op1_is_reg: op1IsReg_i,
        op2_is_reg: op2IsReg_i,
        op3_is_reg: op3IsReg_i,
        op4_is_reg: op4IsReg_i,
        body:       body_i
    };

    assign valid_o = (count != '0);
    assign stall_o = (count >= full_cnt - 1'b1);
    assign count_o = count;
    assign pop     = valid_o & ready_i & ~flush_i;
    // A pop frees the head slot in the same edge, so a full queue still accepts.
    assign push    = enable_i & ~flush_i & ((count < full_cnt) | pop);

    always_ff @(posedge clock_i) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (enable_i && !push) overflow_o <= 1'b1;
        end
    end

    assign head = valid_o ? mem[rd_ptr] : '0;

    assign opcode_o       = head.opcode;
    assign address_o      = head.address;
    assign funcUnitType_o = head.func_unit;
    assign majID_o        = head.maj_id;
    assign minID_o        = head.min_id;
    assign is64Bit_o      = head.is_64bit;
    assign pid_o          = head.pid;
    assign tid_o          = head.tid;
    assign op1rw_o        = head.op1rw;
    assign op2rw_o        = head.op2rw;
    assign op3rw_o        = head.op3rw;
    assign op4rw_o        = head.op4rw;
    assign op1IsReg_o     = head.op1_is_reg;
    assign op2IsReg_o     = head.op2_is_reg;
    assign op3IsReg_o     = head.op3_is_reg;
    assign op4IsReg_o     = head.op4_is_reg;
    assign body_o         = head.body;

endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Show-ahead FIFO directly downstream of the decode mux. Captures each record the mux presents with `enable_i` and holds it until the issue stage accepts it with a valid/ready handshake. Back-pressures the mux with `stall_o`, sized to absorb the mux's one-cycle registered latency. Supports a single-cycle flush for pipeline redirects.

## Interface
Parameters:
- `depth`, 8: number of entries; must be a power of 2, ≥ 4.
- `addressWidth`, 64: instruction address width.
- `opcodeSize`, 12: opcode width.
- `funcUnitCodeSize`, 3: functional-unit code width.
- `instructionCounterWidth`, 64: major ID width.
- `instMinIdWidth`, 7: minor ID width.
- `PidSize`, 20: process ID width.
- `TidSize`, 16: thread ID width.
- `regAccessPatternSize`, 2: per-operand rw field; bit0 = read, bit1 = write.
- `bodyWidth`, 84: operand body width (4 registers + 64-bit immediate).

Ports:
- `clock_i` input 1: single clock; all state updates on rising edge.
- `reset_i` input 1: reset, asynchronous and active-high.
- `flush_i` input 1: synchronous discard of all entries.
- `enable_i` input 1: mux record valid this cycle.
- `opcode_i` / `opcode_o` in/out `opcodeSize`: opcode.
- `address_i` / `address_o` in/out `addressWidth`: instruction address.
- `funcUnitType_i` / `funcUnitType_o` in/out `funcUnitCodeSize`: target unit.
- `majID_i` / `majID_o` in/out `instructionCounterWidth`: major ID.
- `minID_i` / `minID_o` in/out `instMinIdWidth`: minor ID.
- `is64Bit_i` / `is64Bit_o` in/out 1: 64-bit mode.
- `pid_i` / `pid_o` in/out `PidSize`: process ID.
- `tid_i` / `tid_o` in/out `TidSize`: thread ID.
- `op1rw_i`..`op4rw_i` / `op1rw_o`..`op4rw_o` in/out `regAccessPatternSize` each: operand access pattern.
- `op1IsReg_i`..`op4IsReg_i` / `op1IsReg_o`..`op4IsReg_o` in/out 1 each: operand is a register.
- `body_i` / `body_o` in/out `bodyWidth`: operand body.
- `ready_i` input 1: issue stage accepts head this cycle.
- `valid_o` output 1: head entry present.
- `stall_o` output 1: upstream must hold; combinational from count.
- `overflow_o` output 1: sticky; a record was dropped.
- `count_o` output log2(depth)+1: occupancy.

## Operation
- Storage: `depth`-entry register array; `wrPtr`/`rdPtr` are log2(depth) bits and wrap naturally. `count` is log2(depth)+1 bits.
- Push = `enable_i & ~flush_i & (count < depth | pop)`.
- Pop = `valid_o & ready_i & ~flush_i`.
- Push and pop in the same cycle: both pointers advance and `count` is unchanged. This includes the full case, so a push is accepted at `count == depth` when a pop coincides.
- `enable_i` while full with no pop: record dropped, contents unchanged, `overflow_o` ← 1. `overflow_o` clears only on reset.
- `flush_i`: pointers and count ← 0. Flush wins over a simultaneous push or pop; the incoming record is discarded and `overflow_o` is unaffected.
- `valid_o` = (`count != 0`).
- Outputs show the head entry combinationally. All data outputs are forced to 0 when `valid_o == 0`.
- `stall_o` = (`count >= depth-1`). This leaves one slot for the record already in flight from the registered mux.
- `ready_i` while empty has no effect.

## Timing
- Reset (asynchronous): pointers, count, and `overflow_o` = 0. Hence `valid_o` = 0, `stall_o` = 0, `count_o` = 0, all data outputs = 0. Array contents are don't-care.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: a record pushed at edge N appears on outputs with `valid_o` = 1 after edge N, i.e. in the same cycle the mux output would have been consumed. There is no bypass: the queue is never combinationally transparent.
- Pop at edge N: the next entry, or `valid_o` = 0, is visible after edge N.
- `stall_o` changes only after edges (it depends only on `count`).

## Test plan
- Reset, then push 3 records with majID 10, 11, 12 and `ready_i` = 0 → `count_o` = 3, head majID = 10, `stall_o` = 0. Then raise `ready_i` for 3 cycles → majIDs 10, 11, 12 emerge in order, then `valid_o` = 0 with outputs all 0.
- Push 7 records with depth = 8 → `stall_o` = 1 at count 7. Push 1 more → count 8, still no overflow. Push a 9th with `ready_i` = 0 → dropped, `overflow_o` = 1, head unchanged.
- At full, push majID 20 while popping → pop accepted, push accepted, count stays 8, majID 20 is at the tail.
- Fill 5, pop 5, push 6 repeatedly for 20 cycles to force pointer wrap → strict FIFO order of an incrementing majID stream, no loss, no duplicates.
- With count = 4, assert `flush_i` together with `enable_i` and `ready_i` → next cycle count 0, `valid_o` 0, the new record is absent, and `overflow_o` is unchanged.
- Assert `reset_i` between clock edges with count 5 → `valid_o`, `count_o`, and `stall_o` go to 0 immediately. After deassertion, a first push of majID 99 is the head.
